vscale_htif_monitor: RTL
========================

# vscale_htif_monitor

Synthesizable, parametrised test-completion monitor for vscale simulation tops. It polls the `tohost` CSR of one to NUM_CORES cores over the HTIF PCR request/response handshake and clears each nonzero value by writing zero back. It decodes pass/fail per core, enforces a runtime cycle limit, and raises sticky `done`/`pass`/`timeout` status for the simulation wrapper to act on (`$finish`, exit code).

## Interface
Parameters:
- NUM_CORES, 1, number of HTIF PCR channels monitored
- PCR_WIDTH, 64, HTIF PCR data width (`HTIF_PCR_WIDTH`)
- CYCLE_WIDTH, 64, cycle counter and limit width
- POLL_INTERVAL, 16, idle cycles between polls (≥1)

Ports (CW = max(1,$clog2(NUM_CORES))):
- clk  in  1  clock; the block has one clock
- reset  in  1  reset, synchronous and active-high
- max_cycles  in  CYCLE_WIDTH  cycle limit; 0 disables timeout; sampled every cycle
- htif_pcr_req_valid  out  NUM_CORES  per-core request valid, at most one bit set
- htif_pcr_req_ready  in  NUM_CORES  per-core request ready
- htif_pcr_req_rw  out  1  0 = read, 1 = write; shared by all cores
- htif_pcr_req_addr  out  12  always `CSR_ADDR_TO_HOST`
- htif_pcr_req_data  out  PCR_WIDTH  write data, always 0
- htif_pcr_resp_valid  in  NUM_CORES  per-core response valid
- htif_pcr_resp_ready  out  NUM_CORES  per-core response ready
- htif_pcr_resp_data  in  NUM_CORES*PCR_WIDTH  core i at [i*PCR_WIDTH +: PCR_WIDTH]
- done  out  1  sticky; test finished (pass, fail or timeout)
- pass  out  1  sticky; every core reported `tohost`==1
- timeout  out  1  sticky; cycle limit reached
- fail_core  out  CW  index of first failing core
- fail_code  out  PCR_WIDTH  failing `tohost`>>1
- cycle_count  out  CYCLE_WIDTH  cycles since reset, frozen at done

## Operation
- FSM states: IDLE, RD_REQ, RD_RESP, CLR_REQ, CLR_RESP, DONE.
- IDLE: interval counter runs up to POLL_INTERVAL-1. It then selects the current core `cur` and goes to RD_REQ.
- RD_REQ: `req_valid[cur]`=1, rw=0. On `req_ready[cur]` go to RD_RESP.
- RD_RESP: `resp_ready[cur]`=1. On `resp_valid[cur]`, read value v:
  - v==0: advance `cur`, go to IDLE.
  - v==1: set `passed[cur]`, go to CLR_REQ.
  - v odd and >1: fail. `fail_core`=cur, `fail_code`=v>>1, go to CLR_REQ.
  - v even and nonzero (syscall/console traffic, unsupported): ignore, go to CLR_REQ.
- CLR_REQ/CLR_RESP: write 0 with rw=1 using the same handshake. The write response data is ignored. After the clear:
  - if a fail was recorded or all `passed` bits are set, go to DONE;
  - otherwise advance `cur` and go to IDLE.
- `cur` advance: next index mod NUM_CORES whose `passed` bit is clear. Wrap-around goes NUM_CORES-1 → 0.
- DONE: terminal until reset. All valid/ready outputs are 0. `done`=1. `pass`=1 only if all cores passed and no timeout occurred.
- Timeout has priority over everything. When max_cycles≠0 and `cycle_count`==max_cycles-1 at a clock edge, the next state is DONE with `timeout`=1, from any state. An in-flight handshake is abandoned.
- Fail on the same response that reaches the cycle limit: both `timeout` and the fail fields are recorded, and `pass`=0.
- Only the first fail is recorded. DONE is entered after its clear, so no later fail can overwrite it.

## Timing
- Reset (synchronous) values: all outputs 0; state IDLE; `cur`=0; interval counter 0; `passed`=0. Reset applied mid-handshake drops valid/ready on the next edge.
- `cycle_count` increments every cycle outside reset and DONE. Its first value after reset deassertion is 1.
- Request fields are registered, and stay stable while valid is high until ready. Each transfer takes at least one cycle per phase.
- Minimum poll latency: IDLE POLL_INTERVAL cycles, then RD_REQ 1, then RD_RESP 1.
- `done` rises the cycle after the final clear response, or the cycle after the limit edge.
- `resp_ready` is asserted only in RESP states. A response arriving in any other state is ignored.

## Structure
- Shared package/header `vscale_htif_monitor_pkg.vh` contains the state encodings, the `tohost` decode constants (PASS=1), and uses `HTIF_PCR_WIDTH` and `CSR_ADDR_TO_HOST` from the existing includes.
- One sub-module, `vscale_htif_rr_sel`: next-unpassed-core round-robin selector (mask plus pointer → next index).
- The existing verilator top instantiates this block and replaces its inline timeout logic.

## Test plan
- NUM_CORES=1, core returns 0,0 then 1, POLL_INTERVAL=4 → three reads and one clear write. `done`=`pass`=1, `timeout`=0.
- NUM_CORES=1, `tohost`=0x0B → `fail_code`=5, `fail_core`=0, `pass`=0, and a clear write with data 0 is issued.
- NUM_CORES=4: cores 2, 0, 3, 1 pass in that order → polling skips passed cores; `pass`=1 only after core 1's clear.
- max_cycles=100 with `tohost` always 0 → `timeout`=`done`=1 and `cycle_count`=100 on the edge after the limit; outputs stay idle afterward.
- `req_ready` withheld for 7 cycles, random `resp_valid` stalls → valid/rw/data stay stable and no response is accepted outside RESP states.
- Reset asserted during CLR_REQ → next cycle all outputs 0. After reset the first request appears after POLL_INTERVAL cycles.

Source files
------------

// File: rtl/vscale_htif_monitor_pkg.sv
// Shared definitions for the vscale HTIF test-completion monitor:
// FSM encoding, tohost decode constants and HTIF field widths.
package vscale_htif_monitor_pkg;

    localparam int          HTIF_PCR_WIDTH   = 64;
    localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;

    // tohost==1 means pass; odd values above 1 carry a fail code in bits [W-1:1]
    localparam int          TOHOST_PASS      = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_CLR_REQ,
        ST_CLR_RESP,
        ST_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vscale_htif_rr_sel.sv
// Round-robin selector: returns the first core after ptr (wrapping) whose
// mask bit is clear; ptr itself is the last candidate considered.
module vscale_htif_rr_sel
    import vscale_htif_monitor_pkg::*;
#(
    parameter int N  = 1,
    parameter int CW = idx_width(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] next
);

    logic [CW-1:0] cand [1:N];
    logic [N:1]    cand_free;

    generate
        for (genvar gi = 1; gi <= N; gi++) begin : g_cand
            logic [CW:0] sum;
            logic        free;

            // ptr < N and gi <= N, so a single subtraction wraps correctly
            assign sum       = {1'b0, ptr} + (CW+1)'(gi);
            assign cand[gi]  = (sum >= (CW+1)'(N)) ? CW'(sum - (CW+1)'(N)) : CW'(sum);
            assign cand_free[gi] = free;

            always_comb begin
                free = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (cand[gi] == CW'(j) && !mask[j]) begin
                        free = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        next = ptr;
        for (int k = N; k >= 1; k--) begin
            if (cand_free[k]) begin
                next = cand[k];
            end
        end
    end

endmodule

// File: rtl/vscale_htif_monitor.sv
// Polls and clears the tohost CSR of each core over HTIF PCR, decodes
// pass/fail, enforces a cycle limit and raises sticky completion status.
module vscale_htif_monitor
    import vscale_htif_monitor_pkg::*;
#(
    parameter int  NUM_CORES     = 1,
    parameter int  PCR_WIDTH     = HTIF_PCR_WIDTH,
    parameter int  CYCLE_WIDTH   = 64,
    parameter int  POLL_INTERVAL = 16,
    localparam int CW            = idx_width(NUM_CORES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CYCLE_WIDTH-1:0]         max_cycles,
    output logic [NUM_CORES-1:0]           htif_pcr_req_valid,
    input  logic [NUM_CORES-1:0]           htif_pcr_req_ready,
    output logic                           htif_pcr_req_rw,
    output logic [11:0]                    htif_pcr_req_addr,
    output logic [PCR_WIDTH-1:0]           htif_pcr_req_data,
    input  logic [NUM_CORES-1:0]           htif_pcr_resp_valid,
    output logic [NUM_CORES-1:0]           htif_pcr_resp_ready,
    input  logic [NUM_CORES*PCR_WIDTH-1:0] htif_pcr_resp_data,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [CW-1:0]                  fail_core,
    output logic [PCR_WIDTH-1:0]           fail_code,
    output logic [CYCLE_WIDTH-1:0]         cycle_count
);

    localparam int IW = $clog2(POLL_INTERVAL + 1);

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cur_reg, cur_next, rr_next;
    logic [IW-1:0]          cnt_reg, cnt_next;
    logic [NUM_CORES-1:0]   passed_reg, passed_next;
    logic [NUM_CORES-1:0]   cur_onehot, next_onehot;
    logic                   failed_reg, failed_next;
    logic [CW-1:0]          fail_core_next;
    logic [PCR_WIDTH-1:0]   fail_code_next;
    logic                   timeout_next, pass_next;
    logic [PCR_WIDTH-1:0]   resp_word;
    logic                   req_ready_cur, resp_valid_cur, limit_hit;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_sel
            assign cur_onehot[gi]  = (cur_reg == CW'(gi));
            assign next_onehot[gi] = (cur_next == CW'(gi));
        end
    endgenerate

    always_comb begin
        resp_word = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cur_onehot[i]) begin
                resp_word = htif_pcr_resp_data[i*PCR_WIDTH +: PCR_WIDTH];
            end
        end
    end

    assign req_ready_cur     = |(htif_pcr_req_ready & cur_onehot);
    assign resp_valid_cur    = |(htif_pcr_resp_valid & cur_onehot);
    assign limit_hit         = (state_reg != ST_DONE) && (max_cycles != '0) &&
                               (cycle_count == max_cycles - CYCLE_WIDTH'(1));
    assign htif_pcr_req_data = '0;

    vscale_htif_rr_sel #(
        .N  (NUM_CORES),
        .CW (CW)
    ) u_rr_sel (
        .mask (passed_reg),
        .ptr  (cur_reg),
        .next (rr_next)
    );

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        cnt_next       = cnt_reg;
        passed_next    = passed_reg;
        failed_next    = failed_reg;
        fail_core_next = fail_core;
        fail_code_next = fail_code;
        timeout_next   = timeout;
        pass_next      = pass;

        case (state_reg)
            ST_IDLE: begin
                if (cnt_reg == IW'(POLL_INTERVAL - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_RD_REQ;
                end else begin
                    cnt_next = cnt_reg + IW'(1);
                end
            end
            ST_RD_REQ: begin
                if (req_ready_cur) state_next = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (resp_valid_cur) begin
                    if (resp_word == '0) begin
                        cur_next   = rr_next;
                        state_next = ST_IDLE;
                    end else begin
                        // even nonzero values are syscall traffic: cleared, not decoded
                        if (resp_word == PCR_WIDTH'(TOHOST_PASS)) begin
                            passed_next = passed_reg | cur_onehot;
                        end else if (resp_word[0] && !failed_reg) begin
                            failed_next    = 1'b1;
                            fail_core_next = cur_reg;
                            fail_code_next = resp_word >> 1;
                        end
                        state_next = ST_CLR_REQ;
                    end
                end
            end
            ST_CLR_REQ: begin
                if (req_ready_cur) state_next = ST_CLR_RESP;
            end
            ST_CLR_RESP: begin
                if (resp_valid_cur) begin
                    if (failed_reg || (&passed_reg)) begin
                        state_next = ST_DONE;
                    end else begin
                        cur_next   = rr_next;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase

        // cycle limit overrides any state, abandoning an in-flight handshake
        if (limit_hit) begin
            state_next   = ST_DONE;
            timeout_next = 1'b1;
        end

        if (state_next == ST_DONE && state_reg != ST_DONE) begin
            pass_next = (&passed_next) && !failed_next && !timeout_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            cur_reg             <= '0;
            cnt_reg             <= '0;
            passed_reg          <= '0;
            failed_reg          <= 1'b0;
            fail_core           <= '0;
            fail_code           <= '0;
            timeout             <= 1'b0;
            pass                <= 1'b0;
            done                <= 1'b0;
            cycle_count         <= '0;
            htif_pcr_req_valid  <= '0;
            htif_pcr_resp_ready <= '0;
            htif_pcr_req_rw     <= 1'b0;
            htif_pcr_req_addr   <= '0;
        end else begin
            state_reg           <= state_next;
            cur_reg             <= cur_next;
            cnt_reg             <= cnt_next;
            passed_reg          <= passed_next;
            failed_reg          <= failed_next;
            fail_core           <= fail_core_next;
            fail_code           <= fail_code_next;
            timeout             <= timeout_next;
            pass                <= pass_next;
            done                <= (state_next == ST_DONE);
            if (state_reg != ST_DONE) begin
                cycle_count <= cycle_count + CYCLE_WIDTH'(1);
            end
            htif_pcr_req_valid  <= (state_next == ST_RD_REQ || state_next == ST_CLR_REQ)
                                   ? next_onehot : '0;
            htif_pcr_resp_ready <= (state_next == ST_RD_RESP || state_next == ST_CLR_RESP)
                                   ? next_onehot : '0;
            htif_pcr_req_rw     <= (state_next == ST_CLR_REQ);
            htif_pcr_req_addr   <= CSR_ADDR_TO_HOST;
        end
    end

endmodule
